// File: rtl/pe_agu_issuer.sv
`default_nettype none
// ============================================================================
// Module      : pe_agu_issuer
// Description : Loads one AGU instruction and its index stream into the idle
//               half of the ping-pong index buffer. Once the AGU is free, it
//               swaps the halves and pulses start with the latched config.
//               Optional stall counter: define PE_AGU_ISSUER_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_agu_issuer #(
    parameter int IDX_W      = 4,
    parameter int IDX_DEPTH  = 256,
    parameter int IDX_ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    input  logic [1:0]            ins_mode,
    input  logic [7:0]            ins_idx_cnt,
    input  logic [7:0]            ins_trip_cnt,
    input  logic                  ins_is_new,
    input  logic [3:0]            ins_pad_code,
    input  logic                  ins_cut_y,
    input  logic                  idx_valid,
    output logic                  idx_ready,
    input  logic [2*IDX_W-1:0]    idx_data,
    output logic                  switch_idx_buf,
    output logic                  start,
    output logic [1:0]            mode,
    output logic [7:0]            idx_cnt,
    output logic [7:0]            trip_cnt,
    output logic                  is_new,
    output logic [3:0]            pad_code,
    output logic                  cut_y,
    output logic [2*IDX_W-1:0]    idx_wr_data,
    output logic [IDX_ADDR_W-1:0] idx_wr_addr,
    output logic                  idx_wr_en,
    input  logic                  done,
    output logic                  busy
`ifdef PE_AGU_ISSUER_PERF_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    localparam logic [1:0] c_L_IDLE  = 2'd0;
    localparam logic [1:0] c_L_WRITE = 2'd1;
    localparam logic [1:0] c_L_FULL  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;

    logic [1:0]            r_slot_mode;
    logic [7:0]            r_slot_idx_cnt;
    logic [7:0]            r_slot_trip_cnt;
    logic                  r_slot_is_new;
    logic [3:0]            r_slot_pad_code;
    logic                  r_slot_cut_y;
    logic [7:0]            r_wr_ptr;

    logic [1:0]            r_mode;
    logic [7:0]            r_idx_cnt;
    logic [7:0]            r_trip_cnt;
    logic                  r_is_new;
    logic [3:0]            r_pad_code;
    logic                  r_cut_y;

    logic [2*IDX_W-1:0]    r_idx_wr_data;
    logic [IDX_ADDR_W-1:0] r_idx_wr_addr;
    logic                  r_idx_wr_en;
    logic                  r_start;
    logic                  r_start_d1;
    logic                  r_agu_busy;

    logic                  w_ins_hs;
    logic                  w_idx_hs;
    logic                  w_last_idx;
    logic                  w_in_range;
    logic                  w_issue;
    logic                  w_agu_done;

    assign ins_ready  = (r_state == c_L_IDLE) && !rst;
    assign idx_ready  = (r_state == c_L_WRITE) && !rst;
    assign w_ins_hs   = ins_valid && ins_ready;
    assign w_idx_hs   = idx_valid && idx_ready;
    assign w_last_idx = (r_wr_ptr == (r_slot_idx_cnt - 8'd1));
    assign w_in_range = (32'(r_wr_ptr) < IDX_DEPTH);

    // Waiting out the pending write keeps the swap behind the last index.
    assign w_issue    = (r_state == c_L_FULL) && !r_agu_busy && !r_idx_wr_en && !rst;

    // done is stale in the start cycle and the one after it.
    assign w_agu_done = r_agu_busy && done && !r_start && !r_start_d1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_L_IDLE: begin
                if (w_ins_hs) begin
                    w_state_nxt = (ins_idx_cnt == 8'd0) ? c_L_FULL : c_L_WRITE;
                end
            end
            c_L_WRITE: begin
                if (w_idx_hs && w_last_idx) begin
                    w_state_nxt = c_L_FULL;
                end
            end
            c_L_FULL: begin
                if (w_issue) begin
                    w_state_nxt = c_L_IDLE;
                end
            end
            default: w_state_nxt = c_L_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_L_IDLE;
            r_slot_mode     <= 2'd0;
            r_slot_idx_cnt  <= 8'd0;
            r_slot_trip_cnt <= 8'd0;
            r_slot_is_new   <= 1'b0;
            r_slot_pad_code <= 4'd0;
            r_slot_cut_y    <= 1'b0;
            r_wr_ptr        <= 8'd0;
            r_idx_wr_data   <= '0;
            r_idx_wr_addr   <= '0;
            r_idx_wr_en     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx_wr_en <= w_idx_hs && w_in_range;
            if (w_ins_hs) begin
                r_slot_mode     <= ins_mode;
                r_slot_idx_cnt  <= ins_idx_cnt;
                r_slot_trip_cnt <= ins_trip_cnt;
                r_slot_is_new   <= ins_is_new;
                r_slot_pad_code <= ins_pad_code;
                r_slot_cut_y    <= ins_cut_y;
                r_wr_ptr        <= 8'd0;
            end else if (w_idx_hs) begin
                r_wr_ptr <= r_wr_ptr + 8'd1;
            end
            if (w_idx_hs) begin
                r_idx_wr_data <= idx_data;
                r_idx_wr_addr <= IDX_ADDR_W'(r_wr_ptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode     <= 2'd0;
            r_idx_cnt  <= 8'd0;
            r_trip_cnt <= 8'd0;
            r_is_new   <= 1'b0;
            r_pad_code <= 4'd0;
            r_cut_y    <= 1'b0;
            r_start    <= 1'b0;
            r_start_d1 <= 1'b0;
            r_agu_busy <= 1'b0;
        end else begin
            r_start    <= w_issue;
            r_start_d1 <= r_start;
            if (w_issue) begin
                r_mode     <= r_slot_mode;
                r_idx_cnt  <= r_slot_idx_cnt;
                r_trip_cnt <= r_slot_trip_cnt;
                r_is_new   <= r_slot_is_new;
                r_pad_code <= r_slot_pad_code;
                r_cut_y    <= r_slot_cut_y;
                r_agu_busy <= 1'b1;
            end else if (w_agu_done) begin
                r_agu_busy <= 1'b0;
            end
        end
    end

`ifdef PE_AGU_ISSUER_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if ((r_state == c_L_FULL) && r_agu_busy && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign switch_idx_buf = w_issue;
    assign start          = r_start;
    assign mode           = r_mode;
    assign idx_cnt        = r_idx_cnt;
    assign trip_cnt       = r_trip_cnt;
    assign is_new         = r_is_new;
    assign pad_code       = r_pad_code;
    assign cut_y          = r_cut_y;
    assign idx_wr_data    = r_idx_wr_data;
    assign idx_wr_addr    = r_idx_wr_addr;
    assign idx_wr_en      = r_idx_wr_en;
    assign busy           = ((r_state != c_L_IDLE) || r_agu_busy || r_start) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_pe_agu_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_agu_issuer
// Description : Self-checking bench for pe_agu_issuer with a behavioural AGU
//               done model and a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_agu_issuer;

    localparam int IDX_W      = 4;
    localparam int IDX_DEPTH  = 256;
    localparam int IDX_ADDR_W = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  ins_valid;
    logic                  ins_ready;
    logic [1:0]            ins_mode;
    logic [7:0]            ins_idx_cnt;
    logic [7:0]            ins_trip_cnt;
    logic                  ins_is_new;
    logic [3:0]            ins_pad_code;
    logic                  ins_cut_y;
    logic                  idx_valid;
    logic                  idx_ready;
    logic [2*IDX_W-1:0]    idx_data;
    logic                  switch_idx_buf;
    logic                  start;
    logic [1:0]            mode;
    logic [7:0]            idx_cnt;
    logic [7:0]            trip_cnt;
    logic                  is_new;
    logic [3:0]            pad_code;
    logic                  cut_y;
    logic [2*IDX_W-1:0]    idx_wr_data;
    logic [IDX_ADDR_W-1:0] idx_wr_addr;
    logic                  idx_wr_en;
    logic                  done = 1'b1;
    logic                  busy;
`ifdef PE_AGU_ISSUER_PERF_EN
    logic [31:0]           stall_cnt;
`endif

    pe_agu_issuer #(
        .IDX_W      (IDX_W),
        .IDX_DEPTH  (IDX_DEPTH),
        .IDX_ADDR_W (IDX_ADDR_W)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins_mode       (ins_mode),
        .ins_idx_cnt    (ins_idx_cnt),
        .ins_trip_cnt   (ins_trip_cnt),
        .ins_is_new     (ins_is_new),
        .ins_pad_code   (ins_pad_code),
        .ins_cut_y      (ins_cut_y),
        .idx_valid      (idx_valid),
        .idx_ready      (idx_ready),
        .idx_data       (idx_data),
        .switch_idx_buf (switch_idx_buf),
        .start          (start),
        .mode           (mode),
        .idx_cnt        (idx_cnt),
        .trip_cnt       (trip_cnt),
        .is_new         (is_new),
        .pad_code       (pad_code),
        .cut_y          (cut_y),
        .idx_wr_data    (idx_wr_data),
        .idx_wr_addr    (idx_wr_addr),
        .idx_wr_en      (idx_wr_en),
        .done           (done),
        .busy           (busy)
`ifdef PE_AGU_ISSUER_PERF_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // AGU model: done drops the cycle after start and returns after agu_len cycles.
    int agu_len = 4;
    bit stale   = 1'b0;
    int since   = -1;

    always @(posedge clk) begin
        #2;
        if (rst) begin
            since = -1;
            done  = 1'b1;
        end else begin
            if (start) since = 0;
            else if (since >= 0) since = since + 1;
            if (since >= 1 && since <= agu_len) begin
                done = (since == 1 && stale) ? 1'b1 : 1'b0;
            end else begin
                done = 1'b1;
                if (since > agu_len) since = -1;
            end
        end
    end

    // Scoreboard of index-buffer writes and log of issue events.
    logic [IDX_ADDR_W+2*IDX_W-1:0] exp_q[$];
    int         sw_q[$];
    int         st_q[$];
    logic [1:0] st_mode_q[$];
    logic [7:0] st_trip_q[$];
    int         wr_count    = 0;
    int         last_wr_cyc = -1;
    int         done_rise   = -1;
    logic       prev_done   = 1'b1;

    always @(negedge clk) begin
        if (done === 1'b1 && prev_done === 1'b0) done_rise = cyc;
        prev_done = done;
        if (idx_wr_en === 1'b1) begin
            logic [IDX_ADDR_W+2*IDX_W-1:0] e;
            wr_count    = wr_count + 1;
            last_wr_cyc = cyc;
            checks      = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write", idx_wr_addr, idx_wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({idx_wr_addr, idx_wr_data} !== e) begin
                    errors = errors + 1;
                    $display("FAIL wr_entry: got addr=%0d data=%h, required addr=%0d data=%h",
                             idx_wr_addr, idx_wr_data, e[IDX_ADDR_W+2*IDX_W-1:2*IDX_W], e[2*IDX_W-1:0]);
                end
            end
        end
        if (switch_idx_buf === 1'b1) sw_q.push_back(cyc);
        if (start === 1'b1) begin
            st_q.push_back(cyc);
            st_mode_q.push_back(mode);
            st_trip_q.push_back(trip_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        sw_q.delete();
        st_q.delete();
        st_mode_q.delete();
        st_trip_q.delete();
    endtask

    task automatic send_ins(input logic [1:0] m, input logic [7:0] n, input logic [7:0] trip,
                            input logic nw, input logic [3:0] pad, input logic cy, output int acc);
        bit ok = 1'b0;
        acc          = -1;
        ins_mode     = m;
        ins_idx_cnt  = n;
        ins_trip_cnt = trip;
        ins_is_new   = nw;
        ins_pad_code = pad;
        ins_cut_y    = cy;
        ins_valid    = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            mid();
            if (ins_ready === 1'b1) begin
                ok  = 1'b1;
                acc = cyc;
            end
            tick();
        end
        ins_valid = 1'b0;
        checks = checks + 1;
        if (!ok) begin
            errors = errors + 1;
            $display("FAIL ins_accept: got no handshake in 100 cycles, required acceptance");
        end
    endtask

    task automatic send_idx(input logic [2*IDX_W-1:0] d, input logic [IDX_ADDR_W-1:0] a, input int gap);
        bit ok = 1'b0;
        exp_q.push_back({a, d});
        idx_data  = d;
        idx_valid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            mid();
            if (idx_ready === 1'b1) ok = 1'b1;
            tick();
        end
        idx_valid = 1'b0;
        checks = checks + 1;
        if (!ok) begin
            errors = errors + 1;
            $display("FAIL idx_accept: got no handshake in 100 cycles for data %h, required acceptance", d);
        end
        repeat (gap) tick();
    endtask

    task automatic wait_starts(input int n, input int budget);
        int k = 0;
        while (st_q.size() < n && k < budget) begin
            mid();
            k++;
        end
        checks = checks + 1;
        if (st_q.size() < n) begin
            errors = errors + 1;
            $display("FAIL start_timeout: got %0d start pulses, required %0d", st_q.size(), n);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        mid();
        while (busy !== 1'b0 && k < 200) begin
            mid();
            k++;
        end
        checks = checks + 1;
        if (busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL idle_timeout: got busy=%b, required 0", busy);
        end
        tick();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        ins_valid = 1'b0;
        idx_valid = 1'b0;
        idx_data  = '0;
        ins_mode = 2'd0; ins_idx_cnt = 8'd0; ins_trip_cnt = 8'd0;
        ins_is_new = 1'b0; ins_pad_code = 4'd0; ins_cut_y = 1'b0;
        tick();
        tick();
        mid();
        checks = checks + 1;
        if (ins_ready !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_ins_ready_in_reset: got %b, required 0", ins_ready);
        end
        tick();
        rst = 1'b0;
        mid();
        checks = checks + 3;
        if (ins_ready !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL reset_ins_ready: got %b, required 1", ins_ready);
        end
        if ({idx_ready, busy, start, switch_idx_buf, idx_wr_en} !== 5'b0) begin
            errors = errors + 1;
            $display("FAIL reset_ctrl: got %b, required 00000", {idx_ready, busy, start, switch_idx_buf, idx_wr_en});
        end
        if ({mode, idx_cnt, trip_cnt, is_new, pad_code, cut_y, idx_wr_addr, idx_wr_data} !== '0) begin
            errors = errors + 1;
            $display("FAIL reset_cfg: got %h, required 0", {mode, idx_cnt, trip_cnt, is_new, pad_code, cut_y, idx_wr_addr, idx_wr_data});
        end
`ifdef PE_AGU_ISSUER_PERF_EN
        checks = checks + 1;
        if (stall_cnt !== 32'd0) begin
            errors = errors + 1;
            $display("FAIL reset_stall_cnt: got %0d, required 0", stall_cnt);
        end
`endif
        tick();
    endtask

    task automatic test_basic();
        int acc;
        int w0 = wr_count;
        clear_log();
        agu_len = 4;
        send_ins(2'b01, 8'd3, 8'h07, 1'b1, 4'hA, 1'b1, acc);
        send_idx(8'h11, 8'd0, 0);
        send_idx(8'h22, 8'd1, 0);
        send_idx(8'h33, 8'd2, 0);
        wait_starts(1, 30);
        checks = checks + 6;
        if (wr_count - w0 != 3) begin
            errors = errors + 1;
            $display("FAIL basic_wr_count: got %0d, required 3", wr_count - w0);
        end
        if (sw_q.size() != 1 || sw_q[0] != last_wr_cyc + 1) begin
            errors = errors + 1;
            $display("FAIL basic_switch_cycle: got %0d switches (first %0d), required 1 at %0d",
                     sw_q.size(), (sw_q.size() > 0) ? sw_q[0] : -1, last_wr_cyc + 1);
        end
        if (st_q.size() != 1 || sw_q.size() != 1 || st_q[0] != sw_q[0] + 1) begin
            errors = errors + 1;
            $display("FAIL basic_start_cycle: got start count %0d, required 1 start one cycle after switch", st_q.size());
        end
        if (st_mode_q.size() != 1 || st_mode_q[0] !== 2'b01 || st_trip_q[0] !== 8'h07) begin
            errors = errors + 1;
            $display("FAIL basic_cfg_at_start: got mode=%b trip=%h, required mode=01 trip=07",
                     (st_mode_q.size() > 0) ? st_mode_q[0] : 2'bxx, (st_trip_q.size() > 0) ? st_trip_q[0] : 8'hxx);
        end
        if ({idx_cnt, is_new, pad_code, cut_y} !== {8'd3, 1'b1, 4'hA, 1'b1}) begin
            errors = errors + 1;
            $display("FAIL basic_cfg_fields: got cnt=%0d new=%b pad=%h cut=%b, required 3 1 a 1", idx_cnt, is_new, pad_code, cut_y);
        end
        if (busy !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL basic_busy: got %b, required 1 while AGU runs", busy);
        end
        wait_idle();
    endtask

    task automatic test_zero_len();
        int acc;
        int w0 = wr_count;
        clear_log();
        send_ins(2'b10, 8'd0, 8'h55, 1'b0, 4'h3, 1'b0, acc);
        wait_starts(1, 20);
        checks = checks + 3;
        if (wr_count != w0) begin
            errors = errors + 1;
            $display("FAIL zero_no_write: got %0d writes, required 0", wr_count - w0);
        end
        if (sw_q.size() != 1 || st_q.size() != 1 || st_q[0] != sw_q[0] + 1 || st_q[0] - acc > 3 || sw_q[0] <= acc) begin
            errors = errors + 1;
            $display("FAIL zero_issue_latency: got switch=%0d start=%0d, required within 3 cycles of accept %0d",
                     (sw_q.size() > 0) ? sw_q[0] : -1, (st_q.size() > 0) ? st_q[0] : -1, acc);
        end
        if (st_mode_q.size() != 1 || st_mode_q[0] !== 2'b10) begin
            errors = errors + 1;
            $display("FAIL zero_mode: got %b, required 10", (st_mode_q.size() > 0) ? st_mode_q[0] : 2'bxx);
        end
        wait_idle();
    endtask

    task automatic test_overlap();
        int acc;
        int s_a;
        bit bad = 1'b0;
        clear_log();
        agu_len = 20;
        send_ins(2'b00, 8'd4, 8'h40, 1'b1, 4'h5, 1'b0, acc);
        for (int i = 0; i < 4; i++) send_idx(8'hA0 + 8'(i), 8'(i), 0);
        wait_starts(1, 40);
        s_a = (st_q.size() > 0) ? st_q[0] : 0;
        tick();
        send_ins(2'b11, 8'd2, 8'h22, 1'b0, 4'hF, 1'b1, acc);
        send_idx(8'hB0, 8'd0, 0);
        send_idx(8'hB1, 8'd1, 0);
        for (int k = 0; k < 80 && st_q.size() < 2; k++) begin
            mid();
            if (st_q.size() < 2 && start !== 1'b1 && (mode !== 2'b00 || trip_cnt !== 8'h40)) bad = 1'b1;
        end
        checks = checks + 4;
        if (bad) begin
            errors = errors + 1;
            $display("FAIL overlap_cfg_hold: got config change before B start, required mode=00 trip=40 held");
        end
        if (sw_q.size() != 2 || sw_q[1] != done_rise + 1 || sw_q[1] != s_a + 22) begin
            errors = errors + 1;
            $display("FAIL overlap_switch_cycle: got %0d switches (last %0d), required B switch at %0d",
                     sw_q.size(), (sw_q.size() > 0) ? sw_q[sw_q.size()-1] : -1, s_a + 22);
        end
        if (st_q.size() != 2 || sw_q.size() != 2 || st_q[1] != sw_q[1] + 1) begin
            errors = errors + 1;
            $display("FAIL overlap_start_cycle: got %0d starts, required B start one cycle after switch", st_q.size());
        end
        if (st_mode_q.size() != 2 || st_mode_q[1] !== 2'b11 || st_trip_q[1] !== 8'h22) begin
            errors = errors + 1;
            $display("FAIL overlap_b_cfg: got mode=%b trip=%h, required mode=11 trip=22",
                     (st_mode_q.size() > 1) ? st_mode_q[1] : 2'bxx, (st_trip_q.size() > 1) ? st_trip_q[1] : 8'hxx);
        end
`ifdef PE_AGU_ISSUER_PERF_EN
        checks = checks + 1;
        if (stall_cnt == 32'd0) begin
            errors = errors + 1;
            $display("FAIL overlap_stall_cnt: got 0, required nonzero");
        end
`endif
        wait_idle();
        agu_len = 4;
    endtask

    task automatic test_stale_done();
        int acc;
        int s_c;
        clear_log();
        agu_len = 6;
        stale   = 1'b1;
        send_ins(2'b01, 8'd1, 8'h33, 1'b0, 4'h1, 1'b0, acc);
        send_idx(8'hC1, 8'd0, 0);
        wait_starts(1, 30);
        s_c = (st_q.size() > 0) ? st_q[0] : 0;
        send_ins(2'b10, 8'd0, 8'h44, 1'b1, 4'h2, 1'b1, acc);
        wait_starts(2, 40);
        checks = checks + 2;
        if (sw_q.size() != 2 || sw_q[1] != done_rise + 1 || sw_q[1] != s_c + 8) begin
            errors = errors + 1;
            $display("FAIL stale_switch_cycle: got %0d switches (last %0d), required second switch at %0d",
                     sw_q.size(), (sw_q.size() > 0) ? sw_q[sw_q.size()-1] : -1, s_c + 8);
        end
        if (st_q.size() != 2 || sw_q.size() != 2 || st_q[1] != sw_q[1] + 1) begin
            errors = errors + 1;
            $display("FAIL stale_start_cycle: got %0d starts, required second start one cycle after switch", st_q.size());
        end
        wait_idle();
        stale   = 1'b0;
        agu_len = 4;
    endtask

    task automatic test_backpressure();
        int acc;
        int w0 = wr_count;
        clear_log();
        agu_len = 3;
        send_ins(2'b00, 8'd5, 8'h05, 1'b0, 4'h0, 1'b0, acc);
        for (int i = 0; i < 4; i++) send_idx(8'h50 + 8'(i), 8'(i), 1);
        send_idx(8'h54, 8'd4, 0);
        idx_data  = 8'hEE;
        idx_valid = 1'b1;
        mid();
        checks = checks + 1;
        if (idx_ready !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL bp_ready_in_full: got %b, required 0", idx_ready);
        end
        wait_starts(1, 20);
        repeat (3) tick();
        idx_valid = 1'b0;
        checks = checks + 1;
        if (wr_count - w0 != 5) begin
            errors = errors + 1;
            $display("FAIL bp_wr_count: got %0d, required 5", wr_count - w0);
        end
        wait_idle();
        agu_len = 4;
    endtask

    task automatic test_reset_mid();
        int acc;
        int n_sw;
        int n_st;
        bit extra = 1'b0;
        clear_log();
        send_ins(2'b01, 8'd4, 8'h10, 1'b1, 4'h4, 1'b0, acc);
        send_idx(8'h61, 8'd0, 0);
        send_idx(8'h62, 8'd1, 0);
        tick();
        rst  = 1'b1;
        n_sw = sw_q.size();
        n_st = st_q.size();
        tick();
        rst = 1'b0;
        mid();
        checks = checks + 2;
        if (ins_ready !== 1'b1 || busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL rstmid_state: got ins_ready=%b busy=%b, required 1 0", ins_ready, busy);
        end
        for (int k = 0; k < 8; k++) begin
            mid();
            if (sw_q.size() != n_sw || st_q.size() != n_st) extra = 1'b1;
        end
        if (extra) begin
            errors = errors + 1;
            $display("FAIL rstmid_no_issue: got %0d switches %0d starts, required %0d %0d", sw_q.size(), st_q.size(), n_sw, n_st);
        end
        tick();
        send_ins(2'b11, 8'd2, 8'h12, 1'b0, 4'h8, 1'b1, acc);
        send_idx(8'h71, 8'd0, 0);
        send_idx(8'h72, 8'd1, 0);
        wait_starts(n_st + 1, 30);
        checks = checks + 1;
        if (st_mode_q.size() != n_st + 1 || st_mode_q[n_st] !== 2'b11) begin
            errors = errors + 1;
            $display("FAIL rstmid_next_mode: got %0d starts, required one start with mode 11", st_mode_q.size());
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_overlap();
        test_stale_done();
        test_backpressure();
        test_reset_mid();
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL wr_missing: got %0d required writes still pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion by 200000, required finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
